// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, configuration encodings
// and the status bit positions used by the controller's status register.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  localparam logic DATA_BITS_FULL    = 1'b0;
  localparam logic DATA_BITS_REDUCED = 1'b1;
  localparam logic STOP_ONE          = 1'b0;
  localparam logic STOP_TWO          = 1'b1;

  localparam int MIN_BAUD_TICK = 4;

  localparam int STAT_START_COMPLETE_BIT = 0;
  localparam int STAT_DATA_COMPLETE_BIT  = 4;
  localparam int STAT_COMPLETE_BIT       = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit. Resets to 1 so an
// idle serial line is not mistaken for a start bit while coming out of reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops to settle metastability
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive datapath: oversamples the synchronized line at mid-bit,
// frames start/data/parity/stop bits and hands each character to a
// one-entry valid/ready holding register with per-character error flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int BAUD_VALUE_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        a_rst_i,
  input  logic                        rx_i,
  input  logic [BAUD_VALUE_WIDTH-1:0] baud_tick_val_i,
  input  logic                        data_bit_num_i,
  input  logic                        parity_i,
  input  logic                        stop_bit_num_i,
  output logic [DATA_WIDTH-1:0]       rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic                        parity_err_o,
  output logic                        frame_err_o,
  output logic                        overrun_o,
  output logic                        start_complete_o,
  output logic                        data_complete_o,
  output logic                        rx_complete_o
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int IDX_W     = $clog2(DATA_WIDTH);

  localparam logic [BAUD_VALUE_WIDTH-1:0] BAUD_ONE  = BAUD_VALUE_WIDTH'(1);
  localparam logic [BAUD_VALUE_WIDTH-1:0] BAUD_MIN  = BAUD_VALUE_WIDTH'(MIN_BAUD_TICK);
  localparam logic [BIT_CNT_W-1:0]        LAST_FULL = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0]        LAST_RED  = BIT_CNT_W'(DATA_WIDTH - 2);
  localparam logic [BIT_CNT_W-1:0]        CNT_ONE   = BIT_CNT_W'(1);

  rx_state_e state, state_next;

  logic                        rx_s;
  logic [BAUD_VALUE_WIDTH-1:0] baud_cnt;
  logic [BAUD_VALUE_WIDTH-1:0] p_eff;
  logic [BAUD_VALUE_WIDTH-1:0] p_lat;
  logic                        data_red_lat;
  logic                        par_en_lat;
  logic                        stop_two_lat;
  logic [BIT_CNT_W-1:0]        bit_cnt;
  logic [BIT_CNT_W-1:0]        last_bit;
  logic [DATA_WIDTH-1:0]       shift_data;
  logic                        par_acc;
  logic                        frame_acc;
  logic                        stop_idx;
  logic                        final_stop;
  logic                        tick;

  logic start_det, start_ok, data_sample, data_done;
  logic parity_sample, stop_sample, finish, reload;

  sync_2ff u_sync (
    .clk (clk_i),
    .rst (a_rst_i),
    .d   (rx_i),
    .q   (rx_s)
  );

  assign p_eff      = (baud_tick_val_i < BAUD_MIN) ? BAUD_MIN : baud_tick_val_i;
  assign tick       = (baud_cnt == '0);
  assign last_bit   = (data_red_lat == DATA_BITS_REDUCED) ? LAST_RED : LAST_FULL;
  assign final_stop = (stop_two_lat == STOP_TWO) ? stop_idx : 1'b1;

  // FSM state register
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the per-cycle sampling strobes
  always_comb begin
    state_next    = state;
    start_det     = 1'b0;
    start_ok      = 1'b0;
    data_sample   = 1'b0;
    data_done     = 1'b0;
    parity_sample = 1'b0;
    stop_sample   = 1'b0;
    finish        = 1'b0;
    reload        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          start_det  = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          reload = 1'b1;
          if (rx_s) begin
            state_next = ST_IDLE;
          end else begin
            start_ok   = 1'b1;
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          reload      = 1'b1;
          data_sample = 1'b1;
          if (bit_cnt == last_bit) begin
            data_done  = 1'b1;
            state_next = par_en_lat ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          reload        = 1'b1;
          parity_sample = 1'b1;
          state_next    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          reload      = 1'b1;
          stop_sample = 1'b1;
          if (final_stop) begin
            finish     = 1'b1;
            state_next = (frame_acc || !rx_s) ? ST_WAIT_HIGH : ST_IDLE;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bit timing, configuration capture and per-frame accumulation
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      baud_cnt     <= '0;
      p_lat        <= '0;
      data_red_lat <= 1'b0;
      par_en_lat   <= 1'b0;
      stop_two_lat <= 1'b0;
      bit_cnt      <= '0;
      shift_data   <= '0;
      par_acc      <= 1'b0;
      frame_acc    <= 1'b0;
      stop_idx     <= 1'b0;
    end else begin
      if (start_det) begin
        baud_cnt     <= (p_eff >> 1) - BAUD_ONE;
        p_lat        <= p_eff;
        data_red_lat <= data_bit_num_i;
        par_en_lat   <= parity_i;
        stop_two_lat <= stop_bit_num_i;
        bit_cnt      <= '0;
        shift_data   <= '0;
        par_acc      <= 1'b0;
        frame_acc    <= 1'b0;
        stop_idx     <= 1'b0;
      end else if (reload) begin
        baud_cnt <= p_lat - BAUD_ONE;
      end else if (!tick) begin
        baud_cnt <= baud_cnt - BAUD_ONE;
      end
      if (data_sample) begin
        shift_data[bit_cnt[IDX_W-1:0]] <= rx_s;
        bit_cnt                        <= bit_cnt + CNT_ONE;
        par_acc                        <= par_acc ^ rx_s;
      end
      if (parity_sample) begin
        par_acc <= par_acc ^ rx_s;
      end
      if (stop_sample) begin
        stop_idx <= 1'b1;
        if (!rx_s) begin
          frame_acc <= 1'b1;
        end
      end
    end
  end

  // Phase pulses, holding register delivery, overrun and consumer handshake
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      rx_data_o        <= '0;
      rx_valid_o       <= 1'b0;
      parity_err_o     <= 1'b0;
      frame_err_o      <= 1'b0;
      overrun_o        <= 1'b0;
      start_complete_o <= 1'b0;
      data_complete_o  <= 1'b0;
      rx_complete_o    <= 1'b0;
    end else begin
      start_complete_o <= start_ok;
      data_complete_o  <= data_done;
      rx_complete_o    <= finish;
      overrun_o        <= 1'b0;
      if (finish) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o    <= shift_data;
          parity_err_o <= par_en_lat & par_acc;
          frame_err_o  <= frame_acc | ~rx_s;
          rx_valid_o   <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven bit by bit, a
// character-level model predicts each delivery, and a monitor process pops
// and compares whenever the receiver reports a completed character.
module tb_uart_receiver;

  localparam int DW = 8;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b0;
  logic [BW-1:0] baud = 16'd16;
  logic          data_bits = 1'b0;
  logic          par = 1'b0;
  logic          stop_bits = 1'b0;

  logic [DW-1:0] rx_data_o;
  logic          rx_valid_o, parity_err_o, frame_err_o, overrun_o;
  logic          start_complete_o, data_complete_o, rx_complete_o;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_data = 0, n_rx = 0, n_ovr = 0, n_valid = 0;

  logic       held_full = 1'b0;
  logic [7:0] held_data = 8'h00;
  logic       held_perr = 1'b0;
  logic       held_ferr = 1'b0;

  uart_receiver #(.DATA_WIDTH(DW), .BAUD_VALUE_WIDTH(BW)) dut (
    .clk_i            (clk),
    .a_rst_i          (rst),
    .rx_i             (rx),
    .baud_tick_val_i  (baud),
    .data_bit_num_i   (data_bits),
    .parity_i         (par),
    .stop_bit_num_i   (stop_bits),
    .rx_data_o        (rx_data_o),
    .rx_valid_o       (rx_valid_o),
    .rx_ready_i       (rx_ready),
    .parity_err_o     (parity_err_o),
    .frame_err_o      (frame_err_o),
    .overrun_o        (overrun_o),
    .start_complete_o (start_complete_o),
    .data_complete_o  (data_complete_o),
    .rx_complete_o    (rx_complete_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // Character-level model: what the holding register should show after this frame
  task automatic push_expect(input logic [7:0] ch, input bit seven, input bit par_en,
                             input bit par_bit, input bit two, input bit s0, input bit s1,
                             input bit ready_dlv, input bit drained);
    exp_t       e;
    logic [7:0] d;
    d = seven ? {1'b0, ch[6:0]} : ch;
    if (held_full && !ready_dlv) begin
      e = '{held_data, held_perr, held_ferr, 1'b1};
    end else begin
      e.data    = d;
      e.perr    = par_en & ((^d) ^ par_bit);
      e.ferr    = !s0 || (two && !s1);
      e.ovr     = 1'b0;
      held_full = 1'b1;
      held_data = e.data;
      held_perr = e.perr;
      held_ferr = e.ferr;
    end
    if (drained) held_full = 1'b0;
    sb.push_back(e);
  endtask

  task automatic drive_bit(input logic b, input int p);
    rx = b;
    repeat (p) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [7:0] ch, input int nbits, input bit par_en,
                                input bit par_bit, input bit two, input bit s0, input bit s1,
                                input int p);
    drive_bit(1'b0, p);
    for (int i = 0; i < nbits; i++) drive_bit(ch[i], p);
    if (par_en) drive_bit(par_bit, p);
    drive_bit(s0, p);
    if (two) drive_bit(s1, p);
    drive_bit(1'b1, 2 * p);
  endtask

  task automatic set_cfg(input int p, input bit seven, input bit par_en, input bit two);
    baud      = p[BW-1:0];
    data_bits = seven;
    par       = par_en;
    stop_bits = two;
  endtask

  // Full frame with the model prediction pushed before the first bit
  task automatic send_char(input logic [7:0] ch, input int p, input bit seven, input bit par_en,
                           input bit par_bit, input bit two, input bit s0, input bit s1,
                           input bit ready_dlv, input bit drained);
    set_cfg(p, seven, par_en, two);
    push_expect(ch, seven, par_en, par_bit, two, s0, s1, ready_dlv, drained);
    apply_stimulus(ch, seven ? 7 : 8, par_en, par_bit, two, s0, s1, p);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (start_complete_o) n_start++;
      if (data_complete_o) n_data++;
      if (overrun_o) n_ovr++;
      if (rx_valid_o) n_valid++;
      if (rx_complete_o) begin
        n_rx++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_char: got data %0h, required no delivery", rx_data_o);
        end else begin
          e = sb.pop_front();
          check_output("mon_data", 32'(rx_data_o), 32'(e.data));
          check_output("mon_parity_err", 32'(parity_err_o), 32'(e.perr));
          check_output("mon_frame_err", 32'(frame_err_o), 32'(e.ferr));
          check_output("mon_overrun", 32'(overrun_o), 32'(e.ovr));
          check_output("mon_valid", 32'(rx_valid_o), 32'd1);
        end
      end
    end
  endtask

  initial begin
    int c_s, c_d, c_r, c_o, c_v;
    int p;
    bit seven, par_en, two, bad, s0, s1;
    logic [7:0] ch, d;

    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check_output("reset_valid", 32'(rx_valid_o), 32'd0);
    check_output("reset_data", 32'(rx_data_o), 32'd0);
    check_output("reset_flags", {29'd0, parity_err_o, frame_err_o, overrun_o}, 32'd0);
    check_output("reset_pulses", {29'd0, start_complete_o, data_complete_o, rx_complete_o}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rx_ready = 1'b1;

    // 8N1 0xA5: one pulse of each phase and a single valid cycle
    c_s = n_start; c_d = n_data; c_r = n_rx; c_v = n_valid;
    send_char(8'hA5, 16, 0, 0, 0, 0, 1, 1, 1, 1);
    check_output("a5_start_pulses", 32'(n_start - c_s), 32'd1);
    check_output("a5_data_pulses", 32'(n_data - c_d), 32'd1);
    check_output("a5_rx_pulses", 32'(n_rx - c_r), 32'd1);
    check_output("a5_valid_cycles", 32'(n_valid - c_v), 32'd1);

    // Even parity: 0x3C with a wrong then a correct parity bit
    send_char(8'h3C, 16, 0, 1, 1, 0, 1, 1, 1, 1);
    send_char(8'h3C, 16, 0, 1, 0, 0, 1, 1, 1, 1);

    // 7 data bits, 2 stop bits; then second stop bit low
    send_char(8'h55, 20, 1, 0, 0, 1, 1, 1, 1, 1);
    send_char(8'h55, 20, 1, 0, 0, 1, 1, 0, 1, 1);

    // Short low glitch must be rejected
    c_s = n_start; c_r = n_rx;
    set_cfg(16, 0, 0, 0);
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 48);
    check_output("glitch_start_pulses", 32'(n_start - c_s), 32'd0);
    check_output("glitch_rx_pulses", 32'(n_rx - c_r), 32'd0);
    send_char(8'h96, 16, 0, 0, 0, 0, 1, 1, 1, 1);

    // Break: line low for 40 bit periods yields one framing-error 0x00
    c_r = n_rx;
    push_expect(8'h00, 0, 0, 0, 0, 0, 1, 1, 1);
    drive_bit(1'b0, 40 * 16);
    drive_bit(1'b1, 48);
    check_output("break_chars", 32'(n_rx - c_r), 32'd1);

    // Overrun with the consumer stalled, then a load in the delivery cycle
    c_o = n_ovr;
    rx_ready = 1'b0;
    send_char(8'h11, 16, 0, 0, 0, 0, 1, 1, 0, 0);
    send_char(8'h22, 16, 0, 0, 0, 0, 1, 1, 0, 0);
    check_output("held_data", 32'(rx_data_o), 32'h11);
    check_output("overrun_pulses", 32'(n_ovr - c_o), 32'd1);
    set_cfg(16, 0, 0, 0);
    push_expect(8'h33, 0, 0, 0, 0, 1, 1, 1, 0);
    fork
      apply_stimulus(8'h33, 8, 0, 0, 0, 1, 1, 16);
      begin
        repeat (2 + 8 + 9 * 16) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        check_output("dlv_valid_held", 32'(rx_valid_o), 32'd1);
        check_output("dlv_data_33", 32'(rx_data_o), 32'h33);
      end
    join
    check_output("overrun_total", 32'(n_ovr - c_o), 32'd1);
    rx_ready = 1'b1;
    held_full = 1'b0;
    repeat (3) @(negedge clk);
    check_output("drained_valid", 32'(rx_valid_o), 32'd0);

    // Reset in the middle of the data phase with a character held
    rx_ready = 1'b0;
    send_char(8'h5A, 16, 0, 0, 0, 0, 1, 1, 0, 0);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 8);
    rst = 1'b1;
    #1;
    check_output("midrst_valid", 32'(rx_valid_o), 32'd0);
    check_output("midrst_data", 32'(rx_data_o), 32'd0);
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    held_full = 1'b0;
    repeat (20) @(negedge clk);
    rx_ready = 1'b1;
    send_char(8'hC3, 16, 0, 0, 0, 0, 1, 1, 1, 1);

    // Randomized frames against the character model
    for (int n = 0; n < 24; n++) begin
      p      = int'($urandom_range(10, 24));
      seven  = 1'($urandom_range(0, 1));
      par_en = 1'($urandom_range(0, 1));
      two    = 1'($urandom_range(0, 1));
      bad    = ($urandom_range(0, 3) == 0);
      s0     = ($urandom_range(0, 3) != 0);
      s1     = ($urandom_range(0, 3) != 0);
      ch     = 8'($urandom);
      d      = seven ? {1'b0, ch[6:0]} : ch;
      send_char(ch, p, seven, par_en, (^d) ^ bad, two, s0, s1, 1, 1);
    end

    repeat (50) @(negedge clk);
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
